// File: rtl/lwin_pkg.sv
// Shared constants and the tap-index helper for the 3x3 line-window generator.
package lwin_pkg;

    localparam int TAP_N      = 9;
    localparam int DEF_DATA_W = 3;
    localparam int DEF_IMG_W  = 514;
    localparam int DEF_IMG_H  = 480;

    // Flat tap index of window position (r,c); r=0 is the oldest line, c=0 the oldest column.
    function automatic int idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/lwin_line_ram.sv
// One line of pixel history: combinational read, synchronous write with enable.
// Contents are never cleared; the window row counter masks stale data.
module lwin_line_ram #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 514,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read is combinational, so a write in this cycle returns the old word (read-before-write).
    assign rd_data = mem[addr];

    // Write the accepted word at the current column.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wr_data;
    end

endmodule

// File: rtl/line_window_3x3.sv
// 3x3 sliding-window generator for raster-scan pixel streams.
// Two circular line RAMs supply the upper two rows; the window shifts left on every
// accepted pixel. out_valid marks windows fully inside the frame (row>=2, col>=2).
// Optional build macro: LWIN_COORD_OUT_EN adds out_x/out_y window-centre outputs.
module line_window_3x3
    import lwin_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int COL_W  = $clog2(IMG_W),
    parameter int ROW_W  = $clog2(IMG_H)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sof,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    output logic [TAP_N*DATA_W-1:0]   win
`ifdef LWIN_COORD_OUT_EN
    ,
    output logic [COL_W-1:0]          out_x,
    output logic [ROW_W-1:0]          out_y
`endif
);

    logic [COL_W-1:0] col, eff_col;
    logic [ROW_W-1:0] row, eff_row;
    logic             restart, col_last, row_last, win_ok, ram_we;
    logic [DATA_W-1:0] rd_a, rd_b;

    // Window storage indexed [r][c]; column tap [r] is the pixel entering at c=2.
    logic [2:0][2:0][DATA_W-1:0] wreg;
    logic [2:0][DATA_W-1:0]      col_tap;

    // sof forces the current pixel to (0,0) whatever the counters say.
    assign restart  = sof && in_valid;
    assign eff_col  = restart ? '0 : col;
    assign eff_row  = restart ? '0 : row;
    assign col_last = (eff_col == COL_W'(IMG_W - 1));
    assign row_last = (eff_row == ROW_W'(IMG_H - 1));
    assign win_ok   = (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
    assign ram_we   = in_valid && !rst;

    // lineA holds the previous line, lineB the one before it.
    lwin_line_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_line_a (
        .clk     (clk),
        .we      (ram_we),
        .addr    (eff_col),
        .wr_data (in_data),
        .rd_data (rd_a)
    );

    lwin_line_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_line_b (
        .clk     (clk),
        .we      (ram_we),
        .addr    (eff_col),
        .wr_data (rd_a),
        .rd_data (rd_b)
    );

    assign col_tap[0] = rd_b;
    assign col_tap[1] = rd_a;
    assign col_tap[2] = in_data;

    // Raster counters; wrap at end of frame so back-to-back frames need no sof.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : eff_row + ROW_W'(1);
            end else begin
                col <= eff_col + COL_W'(1);
                row <= eff_row;
            end
        end
    end

    // Shift the window left by one column per accepted pixel; hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            wreg <= '0;
        end else if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                wreg[r][0] <= wreg[r][1];
                wreg[r][1] <= wreg[r][2];
                wreg[r][2] <= col_tap[r];
            end
        end
    end

    // Window-valid flag: one cycle after an accept whose window lies inside the frame.
    always_ff @(posedge clk) begin
        if (rst) out_valid <= 1'b0;
        else     out_valid <= in_valid && win_ok;
    end

    genvar gr, gc;
    generate
        for (gr = 0; gr < 3; gr++) begin : g_row
            for (gc = 0; gc < 3; gc++) begin : g_col
                assign win[idx(gr, gc)*DATA_W +: DATA_W] = wreg[gr][gc];
            end
        end
    endgenerate

`ifdef LWIN_COORD_OUT_EN
    // Window-centre coordinates, captured only with a valid window and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_x <= '0;
            out_y <= '0;
        end else if (in_valid && win_ok) begin
            out_x <= eff_col - COL_W'(1);
            out_y <= eff_row - ROW_W'(1);
        end
    end
`endif

endmodule

// File: doc/line_window_3x3.md
Name: line_window_3x3

Overview:
- Parametrised 3x3 sliding-window generator for raster-scan pixel streams, for the edge-detection pipeline (Gaussian/Sobel/NMS stages).
- Replaces the fixed-width two-line shift-register buffer with circular line RAMs, generic pixel width and image size, an input valid/stall qualifier, frame-start resync, and a full 9-tap window with a window-valid flag.
- Sits between the camera capture/greyscale stage and any 3x3 kernel stage.

Parameters:
- DATA_W, 3, pixel width in bits.
- IMG_W, 514, pixels per line (>= 3).
- IMG_H, 480, lines per frame (>= 3).
- COL_W, $clog2(IMG_W), column counter width (derived; do not override).
- ROW_W, $clog2(IMG_H), row counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sof  in  1  start of frame; qualified by in_valid; marks the current pixel as (row 0, col 0).
- in_valid  in  1  in_data carries a pixel this cycle; low = stall.
- in_data  in  DATA_W  incoming pixel, raster order.
- out_valid  out  1  win holds a complete in-frame 3x3 window.
- win  out  9*DATA_W  taps; tap (r,c) at [(3*r+c)*DATA_W +: DATA_W]; r=0 top/oldest line, c=0 left/oldest column; (2,2) = newest pixel.
- out_x  out  COL_W  window-centre column (only with LWIN_COORD_OUT_EN).
- out_y  out  ROW_W  window-centre row (only with LWIN_COORD_OUT_EN).

Behaviour:
- Reset: out_valid=0, win=0, out_x=0, out_y=0. Counters col=0, row=0; window regs 0. Line RAM contents are not cleared (don't-care; masked by the row counter).
- Two line RAMs, depth IMG_W, width DATA_W, with combinational read and read-before-write at address col.
  - Accepted pixel: lineA[col] <= in_data; lineB[col] <= old lineA[col].
  - Column taps this cycle: {old lineB[col], old lineA[col], in_data} for rows 0..2.
- Window regs shift left by one column on each accepted pixel; the new column enters at c=2. No shift, no RAM write and no counter change when in_valid=0; all outputs hold.
- Counters advance on each accepted pixel. At col=IMG_W-1: col->0, row++. At (IMG_W-1, IMG_H-1): both wrap to 0, so back-to-back frames work without sof.
- sof && in_valid: pixel is treated as (0,0) regardless of counter state and written at address 0. Counters continue from (0,1). Mid-frame sof discards the partial frame.
- out_valid is registered and asserts the cycle after accepting pixel (row,col) iff row>=2 && col>=2; otherwise it deasserts on that accept.
  - Latency: 1 cycle.
  - Centre is (row-1, col-1).
  - When in_valid=0, out_valid drops to 0 next cycle; win holds.
- win is updated on every accept, including invalid windows; consumers must gate on out_valid.
- Boundaries:
  - The first two columns of every line never produce out_valid, so there is no wrap contamination between lines.
  - Rows 0-1 never produce out_valid.
  - rst mid-frame wins over in_valid/sof.

Optional Feature:
- LWIN_COORD_OUT_EN defined: out_x/out_y ports exist, registered alongside out_valid and equal to the window centre (col-1, row-1); they hold when not updated.
- Not defined: ports are absent and there is no coordinate logic.

Decomposition:
- Package lwin_pkg: TAP_N=9 constant, tap-index function idx(r,c)=3*r+c, default DATA_W/IMG_W/IMG_H constants.
- One sub-module: lwin_line_ram (parametrised DATA_W x IMG_W, combinational read, synchronous write with enable), instantiated twice.

Test Plan (DATA_W=3, IMG_W=4, IMG_H=4 unless stated):
- Reset then stream pixels p=(4*row+col)%8 with continuous in_valid.
  - First out_valid comes the cycle after pixel (2,2); win = rows {0,1,2} x cols {0,1,2} = {0,1,2,4,5,6,0,1,2}.
  - out_valid count per frame = 4 (2x2 interior).
- Random in_valid gaps (50% duty): window sequence and values are identical to the gap-free run; win/out_x/out_y hold during stalls.
- Columns 0-1 of row 3: out_valid=0 while row is 3 and col<2; no taps from row 2 column 3 appear at c=0..1 of a valid window.
- sof asserted at pixel (1,2) of frame 1: counters restart; next out_valid comes only after 2 more full lines + 3 pixels.
- rst asserted mid-row 2: all outputs 0 next cycle; the following frame matches the first test exactly.
- With LWIN_COORD_OUT_EN and IMG_W=514: on the first valid window, out_x=1 and out_y=1; on the last valid window of the line, out_x=512.
